branch_resolve_queue: RTL and testbench

- Sits directly upstream of the branch statistics counter.
- Holds in-flight predictions (PC plus predicted direction) in program order until the actual outcome arrives.
- Compares the predicted direction with the actual outcome and emits a one-cycle `enable` pulse with `BranchResult` (1 = correctly predicted) that the statistics counter consumes.
- Also flags out-of-order or lost resolutions through a PC check.

---
 rtl/branch_resolve_queue_pkg.sv | 15 +
 rtl/branch_resolve_queue_fifo.sv | 74 +++++++
 rtl/branch_resolve_queue.sv | 92 +++++++++
 tb/tb_branch_resolve_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared branch-predictor types and default sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package branch_resolve_queue_pkg;

  localparam int BP_DEPTH = 8;
  localparam int BP_PC_W  = 32;

  // One in-flight prediction: branch address plus predicted direction.
  typedef struct packed {
    logic [BP_PC_W-1:0] pc;
    logic               taken;
  } bp_entry_t;

endpackage

// File: rtl/branch_resolve_queue_fifo.sv
// In-order DEPTH-entry FIFO of in-flight predictions; dout is always the head entry.
// Latency: a pushed entry is visible at dout one cycle after the push edge (if it is the head).
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
module bp_entry_fifo
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  bp_entry_t        din,
  output bp_entry_t        dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  bp_entry_t        mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  // Occupancy, not pointer equality, decides full/empty so wrap needs no extra bit.
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Next-state for pointers and occupancy; flush returns everything to the empty state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Holds predictions in program order and scores each against its resolved outcome.
// Latency: enable/BranchResult/mismatch_err are registered, one cycle after the resolving edge.
// Backpressure: pred_ready = !full, res_ready = !empty; no same-cycle push-to-resolve bypass.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int PC_W  = BP_PC_W
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_pc,
  output logic             res_ready,
  output logic             BranchResult,
  output logic             enable,
  output logic             mismatch_err,
  output logic [PTR_W:0]   count
);

  bp_entry_t din;
  bp_entry_t head;
  logic      full;
  logic      empty;
  logic      pop_fire;

  logic branch_result_q, branch_result_d;
  logic enable_q, enable_d;
  logic mismatch_q, mismatch_d;

  assign din        = '{pc: pred_pc, taken: pred_taken};
  assign pred_ready = !full;
  assign res_ready  = !empty;
  assign pop_fire   = res_valid && !empty && !flush;

  bp_entry_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .Clk   (Clk),
    .reset (reset),
    .push  (pred_valid),
    .pop   (res_valid),
    .flush (flush),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Score the head entry on a pop; a PC miss still discards the entry but raises an error instead of counting.
  always_comb begin
    enable_d        = 1'b0;
    mismatch_d      = 1'b0;
    branch_result_d = branch_result_q;
    if (pop_fire) begin
      if (res_pc == head.pc) begin
        enable_d        = 1'b1;
        branch_result_d = (res_taken == head.taken);
      end else begin
        mismatch_d      = 1'b1;
        branch_result_d = 1'b0;
      end
    end
  end

  // Registered result outputs.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      branch_result_q <= 1'b0;
      enable_q        <= 1'b0;
      mismatch_q      <= 1'b0;
    end else begin
      branch_result_q <= branch_result_d;
      enable_q        <= enable_d;
      mismatch_q      <= mismatch_d;
    end
  end

  assign BranchResult = branch_result_q;
  assign enable       = enable_q;
  assign mismatch_err = mismatch_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
// Latency: model updates at each rising edge, outputs compared on the following falling edge.
// Backpressure: model accepts pushes only below DEPTH and pops only when non-empty.
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int PC_W  = 32;

  logic            Clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            pred_valid;
  logic            pred_taken;
  logic [PC_W-1:0] pred_pc;
  logic            pred_ready;
  logic            res_valid;
  logic            res_taken;
  logic [PC_W-1:0] res_pc;
  logic            res_ready;
  logic            BranchResult;
  logic            enable;
  logic            mismatch_err;
  logic [PTR_W:0]  count;

  always #5 Clk = ~Clk;

  branch_resolve_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PC_W(PC_W)) dut (
    .Clk          (Clk),
    .reset        (reset),
    .flush        (flush),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_pc      (pred_pc),
    .pred_ready   (pred_ready),
    .res_valid    (res_valid),
    .res_taken    (res_taken),
    .res_pc       (res_pc),
    .res_ready    (res_ready),
    .BranchResult (BranchResult),
    .enable       (enable),
    .mismatch_err (mismatch_err),
    .count        (count)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
  } ent_t;

  ent_t mq[$];
  logic m_en  = 1'b0;
  logic m_br  = 1'b0;
  logic m_mis = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".count"},        32'(count),        32'(mq.size()));
    check({tag, ".pred_ready"},   32'(pred_ready),   32'(mq.size() < DEPTH));
    check({tag, ".res_ready"},    32'(res_ready),    32'(mq.size() > 0));
    check({tag, ".enable"},       32'(enable),       32'(m_en));
    check({tag, ".BranchResult"}, 32'(BranchResult), 32'(m_br));
    check({tag, ".mismatch_err"}, 32'(mismatch_err), 32'(m_mis));
  endtask

  task automatic drive_idle();
    flush      = 1'b0;
    pred_valid = 1'b0;
    pred_taken = 1'b0;
    pred_pc    = '0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    res_pc     = '0;
  endtask

  // One clock of stimulus; starts and ends on a falling edge.
  task automatic step(input logic pv, input logic pt, input logic [31:0] ppc,
                      input logic rv, input logic rt, input logic [31:0] rpc,
                      input logic fl, input string tag);
    bit   can_push;
    bit   can_pop;
    ent_t h;
    ent_t e;
    pred_valid = pv;
    pred_taken = pt;
    pred_pc    = ppc;
    res_valid  = rv;
    res_taken  = rt;
    res_pc     = rpc;
    flush      = fl;
    @(posedge Clk);
    can_push = pv && (mq.size() < DEPTH);
    can_pop  = rv && (mq.size() > 0);
    if (fl) begin
      mq.delete();
      m_en  = 1'b0;
      m_mis = 1'b0;
    end else begin
      m_en  = 1'b0;
      m_mis = 1'b0;
      if (can_pop) begin
        h = mq.pop_front();
        if (rpc == h.pc) begin
          m_en = 1'b1;
          m_br = (rt == h.taken);
        end else begin
          m_mis = 1'b1;
          m_br  = 1'b0;
        end
      end
      if (can_push) begin
        e.pc    = ppc;
        e.taken = pt;
        mq.push_back(e);
      end
    end
    @(negedge Clk);
    drive_idle();
    check_outputs(tag);
  endtask

  task automatic push(input logic [31:0] pc, input logic t, input string tag);
    step(1'b1, t, pc, 1'b0, 1'b0, 32'h0, 1'b0, tag);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic t, input string tag);
    step(1'b0, 1'b0, 32'h0, 1'b1, t, pc, 1'b0, tag);
  endtask

  initial begin
    logic [31:0] rpc;
    reset = 1'b0;
    drive_idle();
    #12;
    check_outputs("reset");
    @(negedge Clk);
    reset = 1'b1;

    // Correct prediction, taken.
    push(32'h100, 1'b1, "p100");
    resolve(32'h100, 1'b1, "r100");
    check("r100.en_const", 32'(enable), 32'd1);
    check("r100.br_const", 32'(BranchResult), 32'd1);

    // Wrong direction, right PC.
    push(32'h104, 1'b0, "p104");
    resolve(32'h104, 1'b1, "r104");
    check("r104.br_const", 32'(BranchResult), 32'd0);

    // Fill, refused 9th push during a pop, then drain across the wrap.
    for (int i = 0; i < DEPTH; i++) push(32'h200 + 32'(4 * i), 1'(i), "fill");
    check("fill.count_const", 32'(count), 32'd8);
    check("fill.pred_ready_const", 32'(pred_ready), 32'd0);
    step(1'b1, 1'b1, 32'h220, 1'b1, 1'b0, 32'h200, 1'b0, "full_pushpop");
    check("full_pushpop.count_const", 32'(count), 32'd7);
    push(32'h220, 1'b1, "retry9");
    for (int i = 0; i < DEPTH; i++) resolve(mq[0].pc, 1'($urandom_range(0, 1)), "drain");

    // Resolve on empty, then same-cycle push+resolve on empty.
    resolve(32'h999, 1'b1, "empty_res");
    step(1'b1, 1'b0, 32'h300, 1'b1, 1'b0, 32'h300, 1'b0, "empty_pushres");
    resolve(32'h300, 1'b0, "r300");

    // PC check: skipping an entry raises the error and drops the head.
    push(32'h400, 1'b1, "p400");
    push(32'h404, 1'b0, "p404");
    resolve(32'h404, 1'b0, "skip");
    check("skip.mis_const", 32'(mismatch_err), 32'd1);
    resolve(32'h404, 1'b0, "r404");

    // Flush with a simultaneous resolve.
    for (int i = 0; i < 3; i++) push(32'h500 + 32'(4 * i), 1'b1, "pf");
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h500, 1'b1, "flush");

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 3; i++) push(32'h600 + 32'(4 * i), 1'b0, "pa");
    resolve(32'h600, 1'b0, "ra");
    #2;
    reset = 1'b0;
    #1;
    mq.delete();
    m_en  = 1'b0;
    m_br  = 1'b0;
    m_mis = 1'b0;
    check_outputs("areset");
    @(negedge Clk);
    reset = 1'b1;

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      if (mq.size() > 0 && $urandom_range(0, 7) != 0) rpc = mq[0].pc;
      else rpc = 32'h1000 + 32'($urandom_range(0, 15) * 4);
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
           32'h1000 + 32'($urandom_range(0, 15) * 4),
           1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 1)), rpc,
           1'($urandom_range(0, 31) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
